huff_stream_encoder: RTL and testbench

HUFF_STREAM_ENCODER -- requirements
Module: huff_stream_encoder

---
 rtl/huff_stream_encoder.sv | 174 +++++++++++++++++
 tb/tb_huff_stream_encoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/huff_stream_encoder.sv
// Batch Huffman code builder: collects up to NSYM {sym,freq} leaves, merges one pair per cycle,
// then streams {sym,len,code} in input order. Define HUFF_COST_EN to add the out_cost port.
module huff_stream_encoder #(
  parameter int NSYM   = 4,
  parameter int SYM_W  = 8,
  parameter int FREQ_W = 3,
  parameter int LEN_W  = $clog2(NSYM) + 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SYM_W-1:0]                          in_sym,
  input  logic [FREQ_W-1:0]                         in_freq,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [SYM_W-1:0]                          out_sym,
  output logic [LEN_W-1:0]                          out_len,
  output logic [NSYM-2:0]                           out_code,
  output logic                                      out_last,
`ifdef HUFF_COST_EN
  output logic [FREQ_W+$clog2(NSYM)+LEN_W-1:0]      out_cost,
`endif
  output logic                                      busy
);
  localparam int WT_W   = FREQ_W + $clog2(NSYM);
  localparam int CODE_W = NSYM - 1;
  localparam int IDX_W  = $clog2(NSYM);
  localparam int CNT_W  = $clog2(NSYM + 1);

  typedef enum logic [1:0] {S_COLLECT, S_MERGE, S_EMIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_n, r_mcnt;
  logic [IDX_W-1:0]    r_idx;
  logic [SYM_W-1:0]    r_sym  [NSYM];
  logic [LEN_W-1:0]    r_len  [NSYM];
  logic [CODE_W-1:0]   r_code [NSYM];
  logic [IDX_W-1:0]    r_gid  [NSYM];
  logic [WT_W-1:0]     r_gw   [NSYM];
  logic [NSYM-1:0]     r_gact;

  logic [IDX_W-1:0]    w_a, w_b, w_lo, w_hi;
  logic [WT_W-1:0]     w_wa, w_wb, w_sum;
  logic                w_fa, w_fb;
  logic [CNT_W-1:0]    w_need;
  logic                w_merge_done, w_last_ent;

`ifdef HUFF_COST_EN
  logic [WT_W+LEN_W-1:0] r_cost;
`endif

  // Two-pass scan: strict '<' keeps the lowest group id on weight ties.
  always_comb begin
    w_a = '0; w_b = '0; w_wa = '0; w_wb = '0; w_fa = 1'b0; w_fb = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      if (r_gact[i] && (!w_fa || r_gw[i] < w_wa)) begin
        w_a = IDX_W'(i); w_wa = r_gw[i]; w_fa = 1'b1;
      end
    end
    for (int i = 0; i < NSYM; i++) begin
      if (r_gact[i] && (IDX_W'(i) != w_a) && (!w_fb || r_gw[i] < w_wb)) begin
        w_b = IDX_W'(i); w_wb = r_gw[i]; w_fb = 1'b1;
      end
    end
  end

  assign w_lo         = (w_a < w_b) ? w_a : w_b;
  assign w_hi         = (w_a < w_b) ? w_b : w_a;
  assign w_sum        = w_wa + w_wb;
  assign w_need       = (r_n <= CNT_W'(1)) ? CNT_W'(1) : (r_n - CNT_W'(1));
  assign w_merge_done = ((r_mcnt + CNT_W'(1)) == w_need);
  assign w_last_ent   = (CNT_W'(r_idx) == (r_n - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_COLLECT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (in_valid && (in_last || r_n == CNT_W'(NSYM - 1))) w_state_nxt = S_MERGE;
      S_MERGE:   if (w_merge_done) w_state_nxt = S_EMIT;
      S_EMIT:    if (out_ready && w_last_ent) w_state_nxt = S_COLLECT;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_COLLECT);
    busy      = (r_state != S_COLLECT);
    out_valid = (r_state == S_EMIT);
    out_last  = (r_state == S_EMIT) && w_last_ent;
    out_sym   = '0;
    out_len   = '0;
    out_code  = '0;
    if (r_state == S_EMIT) begin
      out_sym  = r_sym[r_idx];
      out_len  = r_len[r_idx];
      out_code = r_code[r_idx];
    end
`ifdef HUFF_COST_EN
    out_cost = out_last ? r_cost : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n    <= '0;
      r_mcnt <= '0;
      r_idx  <= '0;
      r_gact <= '0;
      for (int i = 0; i < NSYM; i++) begin
        r_sym[i] <= '0; r_len[i] <= '0; r_code[i] <= '0; r_gid[i] <= '0; r_gw[i] <= '0;
      end
`ifdef HUFF_COST_EN
      r_cost <= '0;
`endif
    end else begin
      case (r_state)
        S_COLLECT: if (in_valid) begin
          r_sym[IDX_W'(r_n)]  <= in_sym;
          r_len[IDX_W'(r_n)]  <= '0;
          r_code[IDX_W'(r_n)] <= '0;
          r_gid[IDX_W'(r_n)]  <= IDX_W'(r_n);
          r_gw[IDX_W'(r_n)]   <= WT_W'(in_freq);
          r_gact[IDX_W'(r_n)] <= 1'b1;
          r_n                 <= r_n + CNT_W'(1);
        end
        S_MERGE: begin
          r_mcnt <= r_mcnt + CNT_W'(1);
          if (r_n <= CNT_W'(1)) begin
            // A lone symbol still needs one transmitted bit.
            r_len[0]  <= LEN_W'(1);
            r_code[0] <= '0;
`ifdef HUFF_COST_EN
            r_cost <= r_cost + (WT_W+LEN_W)'(r_gw[0]);
`endif
          end else begin
            for (int i = 0; i < NSYM; i++) begin
              if (CNT_W'(i) < r_n && (r_gid[i] == w_a || r_gid[i] == w_b)) begin
                r_len[i] <= r_len[i] + LEN_W'(1);
                r_gid[i] <= w_lo;
                if (r_gid[i] == w_b) r_code[i] <= r_code[i] | (CODE_W'(1) << r_len[i]);
              end
            end
            r_gw[w_lo]   <= w_sum;
            r_gact[w_hi] <= 1'b0;
`ifdef HUFF_COST_EN
            // Total cost equals the sum of every merged pair weight.
            r_cost <= r_cost + (WT_W+LEN_W)'(w_sum);
`endif
          end
        end
        S_EMIT: if (out_ready) begin
          if (w_last_ent) begin
            r_n    <= '0;
            r_mcnt <= '0;
            r_idx  <= '0;
            r_gact <= '0;
`ifdef HUFF_COST_EN
            r_cost <= '0;
`endif
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_huff_stream_encoder.sv
// Directed bench for huff_stream_encoder: hand-computed code tables, latency, stall, reset abort.
module tb_huff_stream_encoder;
  localparam int NSYM = 4, SYM_W = 8, FREQ_W = 3, LEN_W = 3, CODE_W = 3;
  localparam int EW = SYM_W + LEN_W + CODE_W + 1;

  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [SYM_W-1:0] in_sym = '0;
  logic [FREQ_W-1:0] in_freq = '0;
  logic in_ready, out_valid, out_last, busy;
  logic [SYM_W-1:0] out_sym;
  logic [LEN_W-1:0] out_len;
  logic [CODE_W-1:0] out_code;
`ifdef HUFF_COST_EN
  logic [FREQ_W+2+LEN_W-1:0] out_cost;
`endif

  int n_checks = 0, n_errors = 0;
  int cyc = 0, hs_cyc = 0;
  logic [EW-1:0] exp_q[$];

  huff_stream_encoder #(.NSYM(NSYM), .SYM_W(SYM_W), .FREQ_W(FREQ_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .in_freq(in_freq), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_len(out_len), .out_code(out_code), .out_last(out_last),
`ifdef HUFF_COST_EN
    .out_cost(out_cost),
`endif
    .busy(busy));

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic [7:0] s, input int len, input int code,
                                        input logic last);
    logic [LEN_W-1:0] l;
    logic [CODE_W-1:0] c;
    l = LEN_W'(len);
    c = CODE_W'(code);
    return {s, l, c, last};
  endfunction

  // Driver: hold one symbol until accepted; records the handshake cycle.
  task automatic send(input logic [7:0] s, input int f, input logic last);
    int w = 0;
    in_valid = 1'b1; in_sym = s; in_freq = FREQ_W'(f); in_last = last;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (w >= 100) check("send_timeout", 32'(w), 0);
    @(posedge clk); #1;
    hs_cyc = cyc;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Receiver/scoreboard: drains exp_q, optionally stalling on one entry.
  task automatic drain(input int stall_idx, input int stall_len, input int exp_lat,
                       input int exp_cost);
    int got = 0, t = 0, held = 0, nexp;
    bit seen = 0;
    nexp = exp_q.size();
    out_ready = 1'b1;
    while (got < nexp && t < 200) begin
      @(negedge clk); t++;
      if (!out_valid) begin
        if (!seen) begin
          check("rdy_while_busy", {31'b0, in_ready}, 0);
          check("busy_flag", {31'b0, busy}, 1);
        end
        out_ready = 1'b1;
      end else begin
        if (!seen) begin
          seen = 1;
          check("latency", 32'(cyc - hs_cyc + 1), 32'(exp_lat));
        end
        check("entry", 32'({out_sym, out_len, out_code, out_last}), 32'(exp_q[0]));
`ifdef HUFF_COST_EN
        check("cost", 32'(out_cost), out_last ? 32'(exp_cost) : 0);
`endif
        if (got == stall_idx && held < stall_len) begin
          out_ready = 1'b0; held++;
        end else begin
          out_ready = 1'b1;
          void'(exp_q.pop_front());
          got++;
        end
      end
    end
    if (got < nexp) check("drain_timeout", 32'(got), 32'(nexp));
    @(negedge clk);
    check("idle_rdy", {31'b0, in_ready}, 1);
    check("idle_busy", {31'b0, busy}, 0);
    check("idle_valid", {31'b0, out_valid}, 0);
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, in_ready}, 1);
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_outs", 32'({out_sym, out_len, out_code, out_last}), 0);

    // Three-symbol batch with in_last
    send(8'h41, 5, 0); send(8'h42, 2, 0); send(8'h43, 1, 1);
    exp_q.push_back(ent(8'h41, 1, 3'b001, 0));
    exp_q.push_back(ent(8'h42, 2, 3'b001, 0));
    exp_q.push_back(ent(8'h43, 2, 3'b000, 1));
    drain(-1, 0, 3, 11);

    // Full batch, equal weights, no in_last
    send(8'h00, 1, 0); send(8'h01, 1, 0); send(8'h02, 1, 0); send(8'h03, 1, 0);
    exp_q.push_back(ent(8'h00, 2, 3'b000, 0));
    exp_q.push_back(ent(8'h01, 2, 3'b001, 0));
    exp_q.push_back(ent(8'h02, 2, 3'b010, 0));
    exp_q.push_back(ent(8'h03, 2, 3'b011, 1));
    drain(-1, 0, 4, 8);

    // Single symbol
    send(8'h7A, 3, 1);
    exp_q.push_back(ent(8'h7A, 1, 0, 1));
    drain(-1, 0, 2, 3);

    // Skewed weights with a zero frequency; stall 5 cycles on entry 1
    send(8'h10, 3, 0); send(8'h11, 3, 0); send(8'h12, 1, 0); send(8'h13, 0, 1);
    exp_q.push_back(ent(8'h10, 2, 3'b011, 0));
    exp_q.push_back(ent(8'h11, 1, 3'b000, 0));
    exp_q.push_back(ent(8'h12, 3, 3'b101, 0));
    exp_q.push_back(ent(8'h13, 3, 3'b100, 1));
    drain(1, 5, 4, 12);

    // Reset in the second MERGE cycle aborts the batch
    send(8'h51, 2, 0); send(8'h52, 3, 0); send(8'h53, 4, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_valid", {31'b0, out_valid}, 0);
      check("abort_busy", {31'b0, busy}, 0);
    end
    send(8'h41, 1, 0); send(8'h42, 1, 1);
    exp_q.push_back(ent(8'h41, 1, 0, 0));
    exp_q.push_back(ent(8'h42, 1, 1, 1));
    drain(-1, 0, 2, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
